enc_trg_decoder: RTL
====================

Name: enc_trg_decoder

Overview:
- Decodes the 3-bit trigger bus ENC_TRG from the crate into single-cycle LCT, L1A, L1A_MATCH and RESYNC strobes for the CFEB.
- Supports both encoded and unencoded bus modes, selected by the TRG_DCD config bit.
- Applies the JTAG-programmed extra L1A delay and maintains LCT/L1A event counters that clear on resync.
- Sits between the ENC_TRG input pins and the SCA/pipeline control logic inside cfeb_hdl.

Parameters:
- CNT_W, 24, width of LCT_CNT and L1A_CNT.
- BAD_W, 8, width of the saturating illegal-code counter.

Ports:
- CMSCLK  in  1  40 MHz CMS clock; every register is clocked on its rising edge.
- RST  in  1  asynchronous active-high reset.
- ENC_TRG  in  3  trigger bus, synchronous to CMSCLK.
- TRG_DCD  in  1  1 = encoded mode, 0 = unencoded mode ({resync,l1a,lct}).
- XL1A_DLY  in  2  extra L1A delay, 0-3 cycles.
- LCT  out  1  LCT strobe.
- L1A  out  1  L1A strobe, after the extra delay.
- L1A_MATCH  out  1  matched-L1A strobe; aligned with L1A.
- RESYNC  out  1  one-cycle pulse at the start of a resync.
- RESYNC_ACT  out  1  level, high while resync is held.
- LCT_CNT  out  CNT_W  LCT count since last reset or resync.
- L1A_CNT  out  CNT_W  L1A count since last reset or resync.
- BAD_CODE  out  1  pulse when an illegal code is decoded.
- BAD_CNT  out  BAD_W  saturating count of illegal codes.

Behaviour:
- Reset: all outputs, counters, the delay line and the input register go to 0.
- Stage 1: ENC_TRG is registered into trg_r on every cycle.
- Encoded decode of trg_r (TRG_DCD=1):
  - 0 = idle
  - 1 = lct
  - 2 = lct+l1a
  - 3 = lct+l1a+match
  - 4 = l1a
  - 5 = l1a+match
  - 6 = illegal
  - 7 = resync
- Unencoded decode (TRG_DCD=0): bit0 = lct, bit1 = l1a, bit2 = resync; match = l1a. Code 6 is not illegal in this mode.
- Resync dominates: whenever resync decodes, lct, l1a and match are forced to 0.
- Stage 2: decoded strobes are registered.
  - LCT, RESYNC_ACT and BAD_CODE appear 2 CMSCLK edges after ENC_TRG is sampled.
- RESYNC = decoded resync AND NOT the previous decoded resync. It pulses once per held resync, regardless of hold length.
- L1A/L1A_MATCH path:
  - Stage-2 l1a/match enter a 3-deep shift line.
  - The output tap is selected by XL1A_DLY, giving a total latency of 2+XL1A_DLY.
  - XL1A_DLY is written only while idle; a change with an L1A in flight may drop or duplicate it.
- Resync flush: in the cycle the stage-2 resync is high, all delay-line stages clear, so pending L1As are discarded.
- Counters:
  - LCT_CNT and L1A_CNT increment on the cycle after their output strobe is high, and wrap modulo 2^CNT_W.
  - They clear on the cycle after RESYNC is high.
  - If a clear and an increment coincide, the clear wins.
- BAD_CNT increments on BAD_CODE, holds at 2^BAD_W-1, and is cleared only by RST (resync does not clear it).
- TRG_DCD is sampled every cycle; a mode change affects codes sampled after it.
- RST asserted mid-operation clears everything immediately, including in-flight L1As. After deassertion, the first ENC_TRG sample is decoded normally.

Optional Feature:
- Macro: ENC_TRG_DEC_TMR_EN.
- Defined: every state register (trg_r, stage 2, delay line, previous-resync flag, counters) is triplicated, with majority voters on the feedback and output paths. Outputs are cycle-identical to the untriplicated version, and a single upset copy is corrected on the next clock.
- Undefined: single copy of every register, no voters.

Test Plan:
- TRG_DCD=1, XL1A_DLY=0; ENC_TRG=1 for 1 cycle -> LCT high 1 cycle at +2, LCT_CNT 0->1; L1A stays 0.
- TRG_DCD=1, XL1A_DLY=1; ENC_TRG=3 for 1 cycle -> LCT at +2; L1A=L1A_MATCH=1 at +3; both counters =1.
- ENC_TRG=7 held 25 cycles after 5 LCTs and 3 L1As ->
  - RESYNC is a single pulse at +2.
  - RESYNC_ACT is high for 25 cycles.
  - LCT_CNT and L1A_CNT read 0 one cycle after the RESYNC pulse.
- XL1A_DLY=3; ENC_TRG=4, then ENC_TRG=7 two cycles later -> no L1A output; L1A_CNT stays at its pre-resync value until the clear, then 0.
- TRG_DCD=1; ENC_TRG=6 held 300 cycles -> BAD_CODE high at every sample; BAD_CNT saturates at 255; no LCT/L1A; a subsequent resync leaves BAD_CNT=255.
- TRG_DCD=0; ENC_TRG=3'b011 for 1 cycle -> LCT, L1A and L1A_MATCH all asserted. Then assert RST mid-delay with XL1A_DLY=3 -> all outputs 0 immediately and no late L1A.

Source files
------------

// File: rtl/enc_trg_decoder.sv
// ENC_TRG trigger-bus decoder: LCT/L1A/L1A_MATCH/RESYNC strobes, extra L1A delay and event counters.
// Define ENC_TRG_DEC_TMR_EN to triplicate all state registers with majority voting.
module enc_trg_decoder #(
  parameter int unsigned CNT_W = 24,
  parameter int unsigned BAD_W = 8
) (
  input  logic             CMSCLK,
  input  logic             RST,
  input  logic [2:0]       ENC_TRG,
  input  logic             TRG_DCD,
  input  logic [1:0]       XL1A_DLY,
  output logic             LCT,
  output logic             L1A,
  output logic             L1A_MATCH,
  output logic             RESYNC,
  output logic             RESYNC_ACT,
  output logic [CNT_W-1:0] LCT_CNT,
  output logic [CNT_W-1:0] L1A_CNT,
  output logic             BAD_CODE,
  output logic [BAD_W-1:0] BAD_CNT
);

  // Complete register state of the block, kept in one word so it can be voted as a whole.
  typedef struct packed {
    logic [2:0]       trg_r;
    logic             dcd_r;
    logic             lct_s2;
    logic             l1a_s2;
    logic             mat_s2;
    logic             rsy_s2;
    logic             rsy_pls;
    logic             bad_s2;
    logic [1:0]       l1a_dl;
    logic [1:0]       mat_dl;
    logic             l1a_o;
    logic             mat_o;
    logic [CNT_W-1:0] lct_cnt;
    logic [CNT_W-1:0] l1a_cnt;
    logic [BAD_W-1:0] bad_cnt;
  } state_t;

  state_t st;
  state_t nx;

  logic lct_d;
  logic l1a_d;
  logic mat_d;
  logic rsy_d;
  logic bad_d;
  logic flush;
  logic l1a_tap;
  logic mat_tap;

  // Decode the registered trigger code; the mode bit travels with the code it was sampled with.
  always_comb begin
    lct_d = 1'b0;
    l1a_d = 1'b0;
    mat_d = 1'b0;
    rsy_d = 1'b0;
    bad_d = 1'b0;
    if (st.dcd_r) begin
      case (st.trg_r)
        3'd1: lct_d = 1'b1;
        3'd2: begin
          lct_d = 1'b1;
          l1a_d = 1'b1;
        end
        3'd3: begin
          lct_d = 1'b1;
          l1a_d = 1'b1;
          mat_d = 1'b1;
        end
        3'd4: l1a_d = 1'b1;
        3'd5: begin
          l1a_d = 1'b1;
          mat_d = 1'b1;
        end
        3'd6: bad_d = 1'b1;
        3'd7: rsy_d = 1'b1;
        default: ;
      endcase
    end else begin
      lct_d = st.trg_r[0];
      l1a_d = st.trg_r[1];
      mat_d = st.trg_r[1];
      rsy_d = st.trg_r[2];
    end
    if (rsy_d) begin
      lct_d = 1'b0;
      l1a_d = 1'b0;
      mat_d = 1'b0;
    end
  end

  // Next state: stage-2 strobes, L1A delay line with resync flush, counters.
  always_comb begin
    nx      = st;
    flush   = st.rsy_s2;
    l1a_tap = 1'b0;
    mat_tap = 1'b0;

    nx.trg_r   = ENC_TRG;
    nx.dcd_r   = TRG_DCD;
    nx.lct_s2  = lct_d;
    nx.l1a_s2  = l1a_d;
    nx.mat_s2  = mat_d;
    nx.rsy_s2  = rsy_d;
    nx.rsy_pls = rsy_d & ~st.rsy_s2;
    nx.bad_s2  = bad_d;

    // Output register loads one stage ahead of the selected tap so L1A stays registered.
    case (XL1A_DLY)
      2'd0: begin
        l1a_tap = l1a_d;
        mat_tap = mat_d;
      end
      2'd1: begin
        l1a_tap = st.l1a_s2;
        mat_tap = st.mat_s2;
      end
      2'd2: begin
        l1a_tap = st.l1a_dl[0];
        mat_tap = st.mat_dl[0];
      end
      default: begin
        l1a_tap = st.l1a_dl[1];
        mat_tap = st.mat_dl[1];
      end
    endcase

    nx.l1a_dl = flush ? 2'b00 : {st.l1a_dl[0], st.l1a_s2};
    nx.mat_dl = flush ? 2'b00 : {st.mat_dl[0], st.mat_s2};
    nx.l1a_o  = l1a_tap & ~(flush & (XL1A_DLY != 2'd0));
    nx.mat_o  = mat_tap & ~(flush & (XL1A_DLY != 2'd0));

    if (st.rsy_pls) begin
      nx.lct_cnt = '0;
      nx.l1a_cnt = '0;
    end else begin
      if (st.lct_s2) nx.lct_cnt = st.lct_cnt + CNT_W'(1);
      if (st.l1a_o)  nx.l1a_cnt = st.l1a_cnt + CNT_W'(1);
    end

    if (st.bad_s2 && (st.bad_cnt != {BAD_W{1'b1}})) nx.bad_cnt = st.bad_cnt + BAD_W'(1);
  end

`ifdef ENC_TRG_DEC_TMR_EN
  state_t st_a;
  state_t st_b;
  state_t st_c;

  always_ff @(posedge CMSCLK or posedge RST) begin
    if (RST) begin
      st_a <= '0;
      st_b <= '0;
      st_c <= '0;
    end else begin
      st_a <= nx;
      st_b <= nx;
      st_c <= nx;
    end
  end

  // Bitwise majority feeds both the next-state logic and the outputs, so one upset copy heals next clock.
  assign st = state_t'((st_a & st_b) | (st_a & st_c) | (st_b & st_c));
`else
  always_ff @(posedge CMSCLK or posedge RST) begin
    if (RST) st <= '0;
    else     st <= nx;
  end
`endif

  assign LCT        = st.lct_s2;
  assign L1A        = st.l1a_o;
  assign L1A_MATCH  = st.mat_o;
  assign RESYNC     = st.rsy_pls;
  assign RESYNC_ACT = st.rsy_s2;
  assign BAD_CODE   = st.bad_s2;
  assign LCT_CNT    = st.lct_cnt;
  assign L1A_CNT    = st.l1a_cnt;
  assign BAD_CNT    = st.bad_cnt;

endmodule
